// File: rtl/rll_key_loader.sv
// Key loader for an RLL-locked core: fetches key words plus an XOR checksum word
// from a key store over req/ack, and presents the key only once the checksum matches.
module rll_key_loader #(
  parameter int KEY_WIDTH  = 32,
  parameter int WORD_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int NWORDS    = KEY_WIDTH / WORD_WIDTH,
  localparam int ADDR_W    = $clog2(NWORDS + 1),
  localparam int TCNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  zeroize,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic [KEY_WIDTH-1:0]  key_out,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, FETCH, GAP, CHECK, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NWORDS);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t                state;
  logic [ADDR_W-1:0]     index;
  logic [KEY_WIDTH-1:0]  staging;
  logic [WORD_WIDTH-1:0] acc;
  logic [WORD_WIDTH-1:0] csum;
  logic [TCNT_W-1:0]     tcount;

  assign mem_addr = index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      index     <= '0;
      staging   <= '0;
      acc       <= '0;
      csum      <= '0;
      tcount    <= '0;
      mem_req   <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else if (zeroize) begin
      state     <= IDLE;
      index     <= '0;
      staging   <= '0;
      acc       <= '0;
      csum      <= '0;
      tcount    <= '0;
      mem_req   <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= FETCH;
            index     <= '0;
            acc       <= '0;
            tcount    <= '0;
            mem_req   <= 1'b1;
            key_out   <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
            error     <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            tcount  <= '0;
            mem_req <= 1'b0;
            if (index == LAST_IDX) begin
              csum  <= mem_data;
              state <= CHECK;
            end else begin
              for (int k = 0; k < NWORDS; k++) begin
                if (index == ADDR_W'(k)) staging[k*WORD_WIDTH +: WORD_WIDTH] <= mem_data;
              end
              acc   <= acc ^ mem_data;
              index <= index + 1'b1;
              state <= GAP;
            end
          end else if (tcount == TCNT_LAST) begin
            // Key store never answered: abandon the load, nothing staged is exposed.
            mem_req <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
            state   <= ERR;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        GAP: begin
          mem_req <= 1'b1;
          state   <= FETCH;
        end
        CHECK: begin
          busy <= 1'b0;
          if (acc == csum) begin
            key_out   <= staging;
            key_valid <= 1'b1;
            state     <= DONE;
          end else begin
            error <= 1'b1;
            state <= ERR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: table of complete loads against a scripted
// key-store responder, followed by hand sequences for start/zeroize/reset corner cases.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        zeroize;
  logic        mem_req;
  logic [2:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        error;

  rll_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .zeroize   (zeroize),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Key store model: word contents and ack delay per address; delay 8'hFF never acks.
  logic [4:0][7:0] mem_w = '0;
  logic [4:0][7:0] mem_d = '0;
  int wait_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req && mem_addr < 3'd5 && mem_d[mem_addr] != 8'hFF &&
        wait_cnt >= int'(mem_d[mem_addr])) begin
      mem_ack  = 1'b1;
      mem_data = mem_w[mem_addr];
    end else begin
      mem_ack  = 1'b0;
      mem_data = 8'h00;
      if (mem_req) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  typedef struct {
    logic [4:0][7:0]  w;
    logic [4:0][7:0]  d;
    logic [31:0]      key;
    logic             valid;
    logic             err;
    int               done;
    logic [4:0][15:0] ac;   // first cycle each address is requested; FFFF = never
  } vec_t;

  function automatic vec_t mk(input logic [39:0] w, input logic [39:0] d, input logic [31:0] key,
                              input logic valid, input logic err, input int done,
                              input logic [79:0] ac);
    mk.w = w; mk.d = d; mk.key = key; mk.valid = valid; mk.err = err; mk.done = done; mk.ac = ac;
  endfunction

  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    done_cyc = -1;
    for (int n = 0; n < 400 && done_cyc < 0; n++) begin
      if (key_valid || error) done_cyc = cyc;
      else step();
    end
  endtask

  task automatic run_vec(input int i);
    int fc[5];
    int done_cyc;
    logic prev_ack;
    mem_w = vecs[i].w;
    mem_d = vecs[i].d;
    for (int k = 0; k < 5; k++) fc[k] = -1;
    done_cyc = -1;
    prev_ack = 1'b0;
    do_start();
    chk("busy_at_c1", busy, 1'b1);
    chk("error_clear_c1", error, 1'b0);
    chk("valid_clear_c1", key_valid, 1'b0);
    for (int n = 0; n < 400 && done_cyc < 0; n++) begin
      if (prev_ack) chk("req_drop_after_ack", mem_req, 1'b0);
      if (mem_req && mem_addr < 3'd5 && fc[mem_addr] < 0) fc[mem_addr] = cyc;
      if (key_valid || error) done_cyc = cyc;
      else begin
        prev_ack = mem_ack && mem_req;
        step();
      end
    end
    chk("done_cycle", done_cyc, vecs[i].done);
    chk("key_out", key_out, vecs[i].key);
    chk("key_valid", key_valid, vecs[i].valid);
    chk("error", error, vecs[i].err);
    chk("busy_end", busy, 1'b0);
    chk("req_end", mem_req, 1'b0);
    for (int k = 0; k < 5; k++)
      if (vecs[i].ac[k] != 16'hFFFF) chk($sformatf("addr%0d_cycle", k), fc[k], vecs[i].ac[k]);
    $display("vec %0d: done_cycle=%0d key_out=%h key_valid=%b error=%b",
             i, done_cyc, key_out, key_valid, error);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_req"}, mem_req, 1'b0);
    chk({nm, "_addr"}, mem_addr, 3'd0);
    chk({nm, "_key"}, key_out, 32'h0);
    chk({nm, "_valid"}, key_valid, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_error"}, error, 1'b0);
  endtask

  localparam logic [39:0] NOM_W  = {8'hFF, 8'hA5, 8'hC3, 8'h0F, 8'h96};
  localparam logic [39:0] BAD_W  = {8'hFE, 8'hA5, 8'hC3, 8'h0F, 8'h96};
  localparam logic [79:0] NOM_AC = {16'd9, 16'd7, 16'd5, 16'd3, 16'd1};

  initial begin
    int done_cyc;
    vecs[0] = mk(NOM_W, 40'h0, 32'hA5C30F96, 1'b1, 1'b0, 11, NOM_AC);
    vecs[1] = mk(BAD_W, 40'h0, 32'h0, 1'b0, 1'b1, 11, NOM_AC);
    vecs[2] = mk(NOM_W, 40'h0, 32'hA5C30F96, 1'b1, 1'b0, 11, NOM_AC);
    vecs[3] = mk(NOM_W, {8'd2, 8'd1, 8'd7, 8'd3, 8'd0}, 32'hA5C30F96, 1'b1, 1'b0, 24,
                 {16'd20, 16'd17, 16'd8, 16'd3, 16'd1});
    vecs[4] = mk(NOM_W, {8'd0, 8'd0, 8'hFF, 8'd0, 8'd0}, 32'h0, 1'b0, 1'b1, 260,
                 {16'hFFFF, 16'hFFFF, 16'd5, 16'd3, 16'd1});
    vecs[5] = mk({8'h0F, 8'h08, 8'h04, 8'h02, 8'h01}, {8'd0, 8'd0, 8'd2, 8'd0, 8'd1},
                 32'h08040201, 1'b1, 1'b0, 14, {16'd12, 16'd10, 16'd6, 16'd4, 16'd1});

    rst_n = 1'b0;
    start = 1'b0;
    zeroize = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("reset");
    $display("reset: outputs at reset values");

    for (int i = 0; i < 6; i++) run_vec(i);

    // Start pulse during FETCH of address 1 must not restart the load.
    mem_w = NOM_W;
    mem_d = '0;
    do_start();
    step_to(3);
    chk("intf_addr1", mem_addr, 3'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(done_cyc);
    chk("intf_done_cycle", done_cyc, 11);
    chk("intf_key", key_out, 32'hA5C30F96);
    chk("intf_valid", key_valid, 1'b1);
    $display("start_while_busy: done_cycle=%0d key_out=%h", done_cyc, key_out);

    // Zeroize in DONE wipes the presented key.
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    chk_idle("zero_done");
    $display("zeroize_in_done: key_out=%h key_valid=%b", key_out, key_valid);

    // Zeroize in the GAP after word 2.
    do_start();
    step_to(6);
    chk("gap_req", mem_req, 1'b0);
    chk("gap_addr", mem_addr, 3'd3);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    chk_idle("zero_gap");
    repeat (3) step();
    chk("zero_gap_stay_busy", busy, 1'b0);
    chk("zero_gap_stay_req", mem_req, 1'b0);
    $display("zeroize_in_gap: busy=%b mem_req=%b", busy, mem_req);

    // Start together with zeroize: zeroize wins.
    start = 1'b1;
    zeroize = 1'b1;
    step();
    start = 1'b0;
    zeroize = 1'b0;
    chk("sz_busy", busy, 1'b0);
    chk("sz_req", mem_req, 1'b0);
    step();
    chk("sz_busy2", busy, 1'b0);
    chk("sz_req2", mem_req, 1'b0);
    $display("start_with_zeroize: busy=%b mem_req=%b", busy, mem_req);

    // Asynchronous reset during CHECK.
    do_start();
    step_to(10);
    chk("chk_busy", busy, 1'b1);
    chk("chk_addr", mem_addr, 3'd4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_addr", mem_addr, 3'd0);
    chk("async_busy", busy, 1'b0);
    chk("async_valid", key_valid, 1'b0);
    chk("async_key", key_out, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (15) step();
    chk("post_rst_valid", key_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    $display("reset_in_check: key_valid=%b busy=%b", key_valid, busy);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
